// File: rtl/alu_bcu_unit.sv
// MIPS execute/decode arithmetic cluster: general adder, 32-bit ALU with HI/LO, branch compare unit.
// Define ALU_DIV_EN to build the DIV/DIVU datapath; otherwise 0E/0F behave as unrecognised codes.
module alu_bcu_unit #(
    parameter int unsigned ADD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADD_WIDTH-1:0] add_a,
    input  logic [ADD_WIDTH-1:0] add_b,
    output logic [ADD_WIDTH-1:0] add_sum,
    input  logic [31:0]          src_a,
    input  logic [31:0]          src_b,
    input  logic [4:0]           alu_control,
    input  logic                 alu_en,
    output logic [31:0]          alu_result,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    input  logic [3:0]           bcu_control,
    input  logic [31:0]          rd1,
    input  logic [31:0]          rd2,
    output logic                 branch
);

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_NOR   = 5'h05;
    localparam logic [4:0] OP_SLT   = 5'h06;
    localparam logic [4:0] OP_SLTU  = 5'h07;
    localparam logic [4:0] OP_SLL   = 5'h08;
    localparam logic [4:0] OP_SRL   = 5'h09;
    localparam logic [4:0] OP_SRA   = 5'h0A;
    localparam logic [4:0] OP_LUI   = 5'h0B;
    localparam logic [4:0] OP_MULT  = 5'h0C;
    localparam logic [4:0] OP_MULTU = 5'h0D;
`ifdef ALU_DIV_EN
    localparam logic [4:0] OP_DIV   = 5'h0E;
    localparam logic [4:0] OP_DIVU  = 5'h0F;
`endif
    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MFLO  = 5'h11;
    localparam logic [4:0] OP_MTHI  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;

    localparam logic [3:0] BC_BEQ  = 4'd0;
    localparam logic [3:0] BC_BNE  = 4'd1;
    localparam logic [3:0] BC_BLEZ = 4'd2;
    localparam logic [3:0] BC_BGTZ = 4'd3;
    localparam logic [3:0] BC_BLTZ = 4'd4;
    localparam logic [3:0] BC_BGEZ = 4'd5;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    assign add_sum = add_a + add_b;
    assign hi      = r_hi;
    assign lo      = r_lo;

    // Explicit 64-bit sign/zero extension keeps the product widths unambiguous.
    assign w_prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign w_prod_u = {32'h0, src_a} * {32'h0, src_b};

`ifdef ALU_DIV_EN
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    // Signed divide via magnitudes; 80000000/-1 falls out naturally as 80000000 rem 0.
    assign w_abs_a = src_a[31] ? (~src_a + 32'd1) : src_a;
    assign w_abs_b = src_b[31] ? (~src_b + 32'd1) : src_b;
    assign w_den_s = (w_abs_b == '0) ? 32'd1 : w_abs_b;
    assign w_den_u = (src_b == '0) ? 32'd1 : src_b;
    assign w_mag_q = w_abs_a / w_den_s;
    assign w_mag_r = w_abs_a % w_den_s;
    assign w_sq    = (src_a[31] ^ src_b[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
    assign w_sr    = src_a[31] ? (~w_mag_r + 32'd1) : w_mag_r;
    assign w_uq    = src_a / w_den_u;
    assign w_ur    = src_a % w_den_u;
`endif

    always_comb begin
        alu_result = '0;
        case (alu_control)
            OP_ADD:  alu_result = src_a + src_b;
            OP_SUB:  alu_result = src_a - src_b;
            OP_AND:  alu_result = src_a & src_b;
            OP_OR:   alu_result = src_a | src_b;
            OP_XOR:  alu_result = src_a ^ src_b;
            OP_NOR:  alu_result = ~(src_a | src_b);
            OP_SLT:  alu_result = {31'h0, $signed(src_a) < $signed(src_b)};
            OP_SLTU: alu_result = {31'h0, src_a < src_b};
            OP_SLL:  alu_result = src_b << src_a[4:0];
            OP_SRL:  alu_result = src_b >> src_a[4:0];
            OP_SRA:  alu_result = $signed(src_b) >>> src_a[4:0];
            OP_LUI:  alu_result = {src_b[15:0], 16'h0};
            OP_MFHI: alu_result = r_hi;
            OP_MFLO: alu_result = r_lo;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (alu_en) begin
            case (alu_control)
                OP_MULT: begin
                    r_hi <= w_prod_s[63:32];
                    r_lo <= w_prod_s[31:0];
                end
                OP_MULTU: begin
                    r_hi <= w_prod_u[63:32];
                    r_lo <= w_prod_u[31:0];
                end
`ifdef ALU_DIV_EN
                OP_DIV: begin
                    r_hi <= (src_b == '0) ? src_a : w_sr;
                    r_lo <= (src_b == '0) ? '1    : w_sq;
                end
                OP_DIVU: begin
                    r_hi <= (src_b == '0) ? src_a : w_ur;
                    r_lo <= (src_b == '0) ? '1    : w_uq;
                end
`endif
                OP_MTHI: r_hi <= src_a;
                OP_MTLO: r_lo <= src_a;
                default: ;
            endcase
        end
    end

    always_comb begin
        branch = 1'b0;
        case (bcu_control)
            BC_BEQ:  branch = (rd1 == rd2);
            BC_BNE:  branch = (rd1 != rd2);
            BC_BLEZ: branch = rd1[31] || (rd1 == '0);
            BC_BGTZ: branch = !rd1[31] && (rd1 != '0);
            BC_BLTZ: branch = rd1[31];
            BC_BGEZ: branch = !rd1[31];
            default: branch = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_bcu_unit.sv
// Directed self-checking bench for alu_bcu_unit; division checks follow ALU_DIV_EN.
module tb_alu_bcu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] add_a, add_b, add_sum;
    logic [31:0] src_a, src_b, alu_result, hi, lo;
    logic [4:0]  alu_control;
    logic        alu_en;
    logic [3:0]  bcu_control;
    logic [31:0] rd1, rd2;
    logic        branch;

    int checks = 0;
    int errors = 0;

    alu_bcu_unit #(.ADD_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .src_a(src_a), .src_b(src_b), .alu_control(alu_control), .alu_en(alu_en),
        .alu_result(alu_result), .hi(hi), .lo(lo),
        .bcu_control(bcu_control), .rd1(rd1), .rd2(rd2), .branch(branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic en);
        @(negedge clk);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        alu_en      = en;
        #1;
    endtask

    task automatic edge_then_idle;
        @(posedge clk);
        #1;
        alu_en = 1'b0;
    endtask

    task automatic bcu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bcu_control = c;
        rd1         = a;
        rd2         = b;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        add_a = '0; add_b = '0;
        src_a = '0; src_b = '0; alu_control = 5'h1F; alu_en = 1'b0;
        bcu_control = 4'hF; rd1 = '0; rd2 = '0;
        #12;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        add_a = 32'hFFFFFFFC; add_b = 32'd4; #1;
        check("add_wrap", add_sum, 32'h0);
        add_a = 32'h00400004; add_b = 32'hFFFFFFF8; #1;
        check("add_neg", add_sum, 32'h003FFFFC);

        alu(5'h00, 32'd7, 32'hFFFFFFFD, 1'b0); check("add", alu_result, 32'd4);
        alu(5'h01, 32'd0, 32'd1, 1'b0);        check("sub", alu_result, 32'hFFFFFFFF);
        alu(5'h05, 32'h0F0F0000, 32'h000000FF, 1'b0); check("nor", alu_result, 32'hF0F0FF00);
        alu(5'h06, 32'hFFFFFFFF, 32'd1, 1'b0); check("slt", alu_result, 32'd1);
        alu(5'h07, 32'hFFFFFFFF, 32'd1, 1'b0); check("sltu", alu_result, 32'd0);
        alu(5'h08, 32'd4, 32'h0000000F, 1'b0); check("sll", alu_result, 32'h000000F0);
        alu(5'h09, 32'd4, 32'h80000000, 1'b0); check("srl", alu_result, 32'h08000000);
        alu(5'h0A, 32'd4, 32'h80000000, 1'b0); check("sra", alu_result, 32'hF8000000);
        alu(5'h0B, 32'd0, 32'h00001234, 1'b0); check("lui", alu_result, 32'h12340000);
        alu(5'h1F, 32'd5, 32'd6, 1'b0);        check("unknown_op", alu_result, 32'h0);

        alu(5'h0C, 32'hFFFFFFFE, 32'd3, 1'b1);
        check("mult_res_zero", alu_result, 32'h0);
        edge_then_idle();
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);
        alu(5'h11, 32'd0, 32'd0, 1'b0); check("mflo", alu_result, 32'hFFFFFFFA);
        alu(5'h10, 32'd0, 32'd0, 1'b0); check("mfhi", alu_result, 32'hFFFFFFFF);

        alu(5'h0D, 32'd5, 32'd7, 1'b0);
        edge_then_idle();
        check("stall_hi", hi, 32'hFFFFFFFF);
        check("stall_lo", lo, 32'hFFFFFFFA);

        alu(5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        edge_then_idle();
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        alu(5'h12, 32'h12345678, 32'd0, 1'b1);
        edge_then_idle();
        alu(5'h13, 32'h9ABCDEF0, 32'd0, 1'b1);
        edge_then_idle();
        check("mthi", hi, 32'h12345678);
        check("mtlo", lo, 32'h9ABCDEF0);

        alu(5'h0E, 32'hFFFFFFF9, 32'd2, 1'b1);
        check("div_res_zero", alu_result, 32'h0);
        edge_then_idle();
`ifdef ALU_DIV_EN
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        alu(5'h0F, 32'd7, 32'd0, 1'b1);
        edge_then_idle();
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd7);
        alu(5'h0E, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        edge_then_idle();
        check("div_ovf_lo", lo, 32'h80000000);
        check("div_ovf_hi", hi, 32'h0);
`else
        check("nodiv_hi", hi, 32'h12345678);
        check("nodiv_lo", lo, 32'h9ABCDEF0);
        alu(5'h0F, 32'd7, 32'd0, 1'b1);
        edge_then_idle();
        check("nodivu_hi", hi, 32'h12345678);
        check("nodivu_lo", lo, 32'h9ABCDEF0);
`endif

        alu(5'h0C, 32'd3, 32'd4, 1'b1);
        edge_then_idle();
        check("mult2_lo", lo, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        check("rst_add_kept", add_sum, 32'h003FFFFC);
        @(negedge clk);
        rst_n = 1'b1;

        bcu(4'd0, 32'd5, 32'd5);               check("beq_eq", {31'h0, branch}, 32'd1);
        bcu(4'd1, 32'd5, 32'd5);               check("bne_eq", {31'h0, branch}, 32'd0);
        bcu(4'd1, 32'd5, 32'd6);               check("bne_ne", {31'h0, branch}, 32'd1);
        bcu(4'd2, 32'd0, 32'd0);               check("blez_0", {31'h0, branch}, 32'd1);
        bcu(4'd3, 32'd0, 32'd0);               check("bgtz_0", {31'h0, branch}, 32'd0);
        bcu(4'd3, 32'd1, 32'd0);               check("bgtz_1", {31'h0, branch}, 32'd1);
        bcu(4'd4, 32'h80000000, 32'd0);        check("bltz_min", {31'h0, branch}, 32'd1);
        bcu(4'd5, 32'h80000000, 32'd0);        check("bgez_min", {31'h0, branch}, 32'd0);
        bcu(4'hF, 32'd5, 32'd5);               check("bcu_undef", {31'h0, branch}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bcu_unit.md
Name: alu_bcu_unit

Overview:
- Execute/decode arithmetic cluster for the 5-stage MIPS pipeline.
- Contains three parts:
  - a general-purpose adder (PC+4 and branch target);
  - a 32-bit ALU with HI/LO registers for mult/div;
  - a branch comparison unit (BCU) that resolves branch conditions in decode.
- The adder, the ALU result and the BCU are combinational. Only HI/LO are clocked.

Parameters:
- ADD_WIDTH, 32, width of the general-purpose adder operands and sum.

Ports:
- clk  input  1  Pipeline clock. HI/LO update on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset. Clears HI/LO.
- add_a  input  ADD_WIDTH  Adder operand A.
- add_b  input  ADD_WIDTH  Adder operand B.
- add_sum  output  ADD_WIDTH  add_a + add_b, modulo 2^ADD_WIDTH.
- src_a  input  32  ALU operand A. For shifts, src_a[4:0] is the shift amount.
- src_b  input  32  ALU operand B. For shifts, src_b is the value shifted.
- alu_control  input  5  ALU operation select.
- alu_en  input  1  Qualifies HI/LO writes. Drive 0 while the execute stage is stalled or flushed.
- alu_result  output  32  ALU result.
- hi  output  32  Current HI register.
- lo  output  32  Current LO register.
- bcu_control  input  4  Branch condition select.
- rd1  input  32  BCU operand 1 (rs, after forwarding).
- rd2  input  32  BCU operand 2 (rt, after forwarding).
- branch  output  1  Branch condition true.

Behaviour:
- Adder: pure combinational, wrap-around, no carry-out.
- ALU result encodings (alu_control, combinational):
  - 00 ADD, 01 SUB, 02 AND, 03 OR, 04 XOR, 05 NOR.
  - 06 SLT (signed, result 1/0), 07 SLTU (unsigned, result 1/0).
  - 08 SLL, 09 SRL, 0A SRA: src_b shifted by src_a[4:0].
  - 0B LUI: {src_b[15:0],16'h0}.
  - 10 MFHI: result = hi. 11 MFLO: result = lo.
  - All other codes, including 0C–0F and 12–13: result 0.
- ADD/SUB: wrap-around, no overflow trap.
- HI/LO writes (rising clk, only when alu_en=1):
  - 0C MULT: signed 64-bit product; {hi,lo} = product.
  - 0D MULTU: unsigned 64-bit product; {hi,lo} = product.
  - 0E DIV (signed): lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0F DIVU: unsigned quotient/remainder.
  - 12 MTHI: hi = src_a. 13 MTLO: lo = src_a.
- Division edge cases:
  - Divide by zero: lo = 32'hFFFFFFFF, hi = src_a.
  - Signed 32'h80000000 / -1: lo = 32'h80000000, hi = 0.
- HI/LO hold:
  - alu_en=0 or any other code: HI/LO hold.
  - A write and a same-cycle MFHI/MFLO read: the read returns the pre-edge value. No internal bypass.
- Reset: rst_n low immediately forces hi=lo=0, independent of clk. A mult/div in flight when reset asserts is discarded. The combinational outputs (alu_result, branch, add_sum) are not affected by reset.
- BCU encodings (bcu_control, combinational; rd1/rd2 compared as signed where ordered):
  - 0 BEQ: rd1==rd2.
  - 1 BNE: rd1!=rd2.
  - 2 BLEZ: rd1<=0.
  - 3 BGTZ: rd1>0.
  - 4 BLTZ: rd1<0.
  - 5 BGEZ: rd1>=0.
  - 6–15: branch=0.
  - The caller ANDs branch with its decoded branch enable.

Optional Feature:
- ALU_DIV_EN
  - Defined: DIV/DIVU (0E/0F) are implemented as above. A single-cycle combinational divider is acceptable.
  - Undefined: 0E/0F are treated as unrecognised codes: HI/LO hold, alu_result=0, and no divider logic is synthesised.
  - MULT/MULTU/MTHI/MTLO are unaffected either way.

Test Plan:
- Reset and adder:
  - rst_n=0 mid-run after a MULT -> hi=lo=0 immediately.
  - add_a=32'hFFFFFFFC, add_b=4 -> add_sum=0.
  - add_a=32'h00400004, add_b=32'hFFFFFFF8 -> add_sum=32'h003FFFFC.
- ALU basics:
  - ADD 7+(-3) -> 4.
  - SUB 0-1 -> 32'hFFFFFFFF.
  - SLT -1<1 -> 1; SLTU same operands -> 0.
  - SRA 32'h80000000 by 4 -> 32'hF8000000.
  - LUI 16'h1234 -> 32'h12340000.
- MULT/MFHI/MFLO, then a stalled write:
  - MULT -2×3 with alu_en=1, edge -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; MFLO in the next cycle returns 32'hFFFFFFFA.
  - Repeat with alu_en=0 -> HI/LO unchanged.
- Division (ALU_DIV_EN defined):
  - DIV -7/2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - DIVU 7/0 -> lo=32'hFFFFFFFF, hi=7.
  - With the macro undefined, the same DIV -7/2 leaves HI/LO at their prior values.
- BCU:
  - BEQ 5,5 -> 1; BNE 5,5 -> 0.
  - BLEZ 0 -> 1; BGTZ 0 -> 0.
  - BLTZ 32'h80000000 -> 1; BGEZ 32'h80000000 -> 0.
  - bcu_control=4'hF -> 0.
